// File: rtl/fifo_rd_packer.sv
// Reads bytes from a two-cycle-latency FIFO read port and packs them, in arrival order,
// into 32-bit words with byte enables; a flush pulse emits any partially assembled word.
module fifo_rd_packer #(
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic        rclk,
    input  logic        rst_n,
    input  logic        rempty,
    output logic        rinc,
    input  logic [7:0]  rdata,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        busy
);
    localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    logic                  run_q;
    logic [1:0]            rd_pipe_q, rd_pipe_d;
    logic [7:0]            skid_mem_q [SKID_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       skid_cnt_q, skid_cnt_d;
    logic [3:0][7:0]       lane_q, lane_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_data_q, out_data_d;
    logic [3:0]            out_be_q, out_be_d;
    logic                  flush_pend_q, flush_pend_d;

    logic [1:0]            inflight;
    logic [OccW-1:0]       occ;
    logic                  capture, pop, skid_nonempty, out_free, xfer_full, flush_fire;
    logic [3:0]            part_be;
    logic [31:0]           part_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // rd_pipe_q[1] marks the cycle in which an accepted read's byte sits on rdata.
    assign inflight      = {1'b0, rd_pipe_q[0]} + {1'b0, rd_pipe_q[1]};
    assign occ           = OccW'(inflight) + OccW'(skid_cnt_q);
    assign rinc          = run_q & ~rempty & ~flush_pend_q & (occ < OccW'(SKID_DEPTH));
    assign capture       = rd_pipe_q[1];
    assign skid_nonempty = (skid_cnt_q != '0);
    assign pop           = skid_nonempty & (cnt_q != 3'd4);
    assign out_free      = ~out_valid_q | out_ready;
    assign xfer_full     = (cnt_q == 3'd4) & out_free;
    // A full word at the flush point leaves through the normal transfer first.
    assign flush_fire    = flush_pend_q & (inflight == 2'd0) & ~skid_nonempty & out_free &
                           (cnt_q != 3'd4);

    always_comb begin
        part_be = 4'b0000;
        case (cnt_q)
            3'd1:    part_be = 4'b0001;
            3'd2:    part_be = 4'b0011;
            3'd3:    part_be = 4'b0111;
            default: part_be = 4'b0000;
        endcase
        part_data = '0;
        for (int i = 0; i < 4; i++) begin
            part_data[i*8 +: 8] = part_be[i] ? lane_q[i] : 8'h00;
        end
    end

    always_comb begin
        rd_pipe_d    = {rd_pipe_q[0], rinc};
        skid_cnt_d   = skid_cnt_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_be_d     = out_be_q;
        flush_pend_d = flush_pend_q;

        case ({capture, pop})
            2'b10:   skid_cnt_d = skid_cnt_q + 1'b1;
            2'b01:   skid_cnt_d = skid_cnt_q - 1'b1;
            default: skid_cnt_d = skid_cnt_q;
        endcase

        if (pop) begin
            lane_d[cnt_q[1:0]] = skid_mem_q[rd_ptr_q];
            cnt_d              = cnt_q + 3'd1;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (xfer_full) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_q;
            out_be_d    = 4'b1111;
            cnt_d       = 3'd0;
        end else if (flush_fire && (cnt_q != 3'd0)) begin
            out_valid_d = 1'b1;
            out_data_d  = part_data;
            out_be_d    = part_be;
            cnt_d       = 3'd0;
        end

        if (flush_pend_q) begin
            if (flush_fire) begin
                flush_pend_d = 1'b0;
            end
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            rd_pipe_q    <= 2'b00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            skid_cnt_q   <= '0;
            lane_q       <= '0;
            cnt_q        <= 3'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_be_q     <= 4'b0000;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid_mem_q[i] <= 8'h00;
            end
        end else begin
            run_q        <= 1'b1;
            rd_pipe_q    <= rd_pipe_d;
            skid_cnt_q   <= skid_cnt_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_be_q     <= out_be_d;
            flush_pend_q <= flush_pend_d;
            if (capture) begin
                skid_mem_q[wr_ptr_q] <= rdata;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_be    = out_be_q;
    assign busy      = (inflight != 2'd0) | skid_nonempty | (cnt_q != 3'd0) | out_valid_q |
                       flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a byte-source FIFO model with two-cycle read latency feeds the DUT;
// expected words are queued as bytes are offered and compared on each output handshake.
module tb_fifo_rd_packer;
    logic        rclk, rst_n, rempty, rinc, flush, out_valid, out_ready, busy;
    logic [7:0]  rdata;
    logic [31:0] out_data;
    logic [3:0]  out_be;

    logic [7:0]  src_q[$];
    logic [35:0] exp_q[$];
    logic        acc, stage_vld;
    logic [7:0]  acc_byte, stage;
    logic        rdy_req, rdy_rand, flush_req, toggle;
    int unsigned cyc, n_checks, n_fail, n_words;
    logic [31:0] mdl_word;
    int          mdl_n;

    fifo_rd_packer #(.SKID_DEPTH(4)) u_dut (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_be    (out_be),
        .busy      (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Offer a byte and track the word it will land in.
    task automatic push_byte(input logic [7:0] b);
        src_q.push_back(b);
        mdl_word[mdl_n*8 +: 8] = b;
        mdl_n++;
        if (mdl_n == 4) begin
            exp_q.push_back({4'hF, mdl_word});
            mdl_n    = 0;
            mdl_word = '0;
        end
    endtask

    task automatic model_flush();
        if (mdl_n > 0) exp_q.push_back({4'((1 << mdl_n) - 1), mdl_word});
        mdl_n    = 0;
        mdl_word = '0;
    endtask

    task automatic tb_clear();
        src_q.delete();
        exp_q.delete();
        acc       = 1'b0;
        stage_vld = 1'b0;
        mdl_n     = 0;
        mdl_word  = '0;
    endtask

    // One cycle: drive inputs after the falling edge, then look at what the next rising edge sees.
    task automatic step();
        @(negedge rclk);
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_req;
        flush     = flush_req;
        flush_req = 1'b0;
        rdata     = stage_vld ? stage : 8'hEE;
        stage_vld = acc;
        stage     = acc_byte;
        rempty    = (src_q.size() == 0) || (toggle && cyc[0]);
        #1;
        check_eq("rinc_while_empty", 64'(rinc & rempty), 64'd0);
        acc = rinc && !rempty;
        if (acc) acc_byte = src_q.pop_front();
        if (rst_n && out_valid && out_ready) begin
            n_words++;
            check_eq("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_eq("word", 64'({out_be, out_data}), 64'(exp_q.pop_front()));
        end
        cyc++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || acc || stage_vld || busy) && n < 400) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int busy_cnt;
        int snap;
        n_checks = 0; n_fail = 0; n_words = 0; cyc = 0;
        rdy_req = 1'b1; rdy_rand = 1'b0; flush_req = 1'b0; toggle = 1'b0;
        out_ready = 1'b1; flush = 1'b0; rempty = 1'b1; rdata = 8'h00;
        acc_byte = 8'h00; stage = 8'h00;
        tb_clear();

        // Reset values
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_rinc", 64'(rinc), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_be", 64'(out_be), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        exp_q.push_back({4'hF, 32'h44332211});
        repeat (3) step();
        rst_n = 1'b1;
        #1 check_eq("rinc_before_first_edge", 64'(rinc), 64'd0);
        wait_idle("basic");

        // Back-pressure: 12 bytes fit (output, assembly, skid), the rest must wait
        rdy_req = 1'b0;
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
        exp_q.push_back({4'hF, 32'h04030201});
        exp_q.push_back({4'hF, 32'h08070605});
        exp_q.push_back({4'hF, 32'h0C0B0A09});
        exp_q.push_back({4'hF, 32'h100F0E0D});
        repeat (40) step();
        check_eq("stall_src_left", 64'(src_q.size()), 64'd4);
        check_eq("stall_rinc", 64'(rinc), 64'd0);
        check_eq("stall_busy", 64'(busy), 64'd1);
        check_eq("stall_out_data", 64'(out_data), 64'h04030201);
        rdy_req = 1'b1;
        wait_idle("stall");

        // Partial word via flush
        src_q.push_back(8'hA1); src_q.push_back(8'hB2); src_q.push_back(8'hC3);
        exp_q.push_back({4'h7, 32'h00C3B2A1});
        repeat (8) step();
        flush_req = 1'b1;
        wait_idle("flush3");

        // Flush with nothing buffered
        snap = int'(n_words);
        busy_cnt = 0;
        flush_req = 1'b1;
        step();
        repeat (6) begin
            step();
            if (busy) busy_cnt++;
        end
        check_eq("flush_empty_busy_le1", 64'(busy_cnt <= 1), 64'd1);
        check_eq("flush_empty_no_word", 64'(int'(n_words) - snap), 64'd0);
        check_eq("flush_empty_idle", 64'(busy), 64'd0);

        // Full word then partial at flush
        for (int i = 0; i < 6; i++) push_byte(8'(8'h30 + i));
        model_flush();
        repeat (12) step();
        flush_req = 1'b1;
        wait_idle("flush6");

        // rempty toggling, random back-pressure
        toggle = 1'b1; rdy_rand = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom));
        wait_idle("toggle");
        toggle = 1'b0; rdy_rand = 1'b0;

        // Reset with reads in flight and three bytes assembled
        src_q.push_back(8'hD1); src_q.push_back(8'hD2); src_q.push_back(8'hD3);
        repeat (10) step();
        src_q.push_back(8'h91); src_q.push_back(8'h92);
        src_q.push_back(8'h93); src_q.push_back(8'h94);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rinc", 64'(rinc), 64'd0);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_data", 64'(out_data), 64'd0);
        check_eq("midrst_out_be", 64'(out_be), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        tb_clear();
        repeat (2) step();
        push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C); push_byte(8'h8D);
        step();
        rst_n = 1'b1;
        #1 check_eq("midrst_rinc_release", 64'(rinc), 64'd0);
        wait_idle("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
